// File: rtl/hetic_cfg_loader.sv
// OBI manager that writes one interrupt-line configuration per command into the
// hetic register file, with optional read-back verify and response timeout.
module hetic_cfg_loader #(
  parameter int unsigned NrIrqLines = 64,
  parameter int unsigned NrIrqPrios = 32,
  parameter logic [31:0] BaseAddr   = 32'h0,
  parameter int unsigned RspTimeout = 16,
  localparam int unsigned IrqWidth  = $clog2(NrIrqLines),
  localparam int unsigned PrioWidth = $clog2(NrIrqPrios)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [IrqWidth-1:0]  cfg_idx_i,
  input  logic [5:0]           cfg_ctrl_i,
  input  logic [PrioWidth-1:0] cfg_prio_i,
  input  logic                 cfg_verify_i,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [31:0]          obi_addr_o,
  output logic                 obi_we_o,
  output logic [3:0]           obi_be_o,
  output logic [31:0]          obi_wdata_o,
  input  logic                 obi_rvalid_i,
  input  logic [31:0]          obi_rdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic [IrqWidth-1:0]  err_idx_o,
  input  logic                 err_clr_i
);

  localparam int unsigned CntWidth = $clog2(RspTimeout + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(RspTimeout);
  localparam logic [1:0] ErrMismatch = 2'b01;
  localparam logic [1:0] ErrTimeout  = 2'b10;
  // ip (bit 1) and the spare bits [7:6] / [15:8+PrioWidth] are not compared on read-back
  localparam logic [15:0] CmpMask = {8'((2 ** PrioWidth) - 1), 8'h3D};

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RSP,
    RD_REQ,
    RD_RSP
  } state_e;

  state_e               state_q, state_d;
  logic [IrqWidth-1:0]  idx_q, idx_d;
  logic [5:0]           ctrl_q, ctrl_d;
  logic [PrioWidth-1:0] prio_q, prio_d;
  logic                 verify_q, verify_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [IrqWidth-1:0]  err_idx_q, err_idx_d;

  logic [15:0]          exp_half;
  logic [15:0]          rsp_half;
  logic                 mismatch;
  logic [CntWidth-1:0]  cnt_inc;
  logic                 rsp_timeout;
  logic [15:0]          cmd_half;
  logic                 new_err;
  logic [1:0]           new_code;

  assign exp_half    = {8'(prio_q), 2'b00, ctrl_q};
  assign rsp_half    = idx_q[0] ? obi_rdata_i[31:16] : obi_rdata_i[15:0];
  assign mismatch    = ((rsp_half ^ exp_half) & CmpMask) != 16'h0000;
  assign cnt_inc     = cnt_q + CntWidth'(1);
  assign rsp_timeout = (cnt_inc == CntMax);
  assign cmd_half    = {8'(cfg_prio_i), 2'b00, cfg_ctrl_i};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ctrl_d     = ctrl_q;
    prio_d     = prio_q;
    verify_d   = verify_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    new_err    = 1'b0;
    new_code   = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          idx_d    = cfg_idx_i;
          ctrl_d   = cfg_ctrl_i;
          prio_d   = cfg_prio_i;
          verify_d = cfg_verify_i;
          req_d    = 1'b1;
          we_d     = 1'b1;
          // two lines share one 32-bit word, odd lines in the upper half
          addr_d   = BaseAddr + 32'({cfg_idx_i[IrqWidth-1:1], 2'b00});
          be_d     = cfg_idx_i[0] ? 4'b1100 : 4'b0011;
          wdata_d  = cfg_idx_i[0] ? {cmd_half, 16'h0000} : {16'h0000, cmd_half};
          state_d  = WR_REQ;
        end
      end
      WR_REQ: begin
        if (obi_gnt_i) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = WR_RSP;
        end
      end
      WR_RSP: begin
        if (obi_rvalid_i) begin
          if (verify_q) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            state_d = RD_REQ;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
          if (rsp_timeout) begin
            new_err  = 1'b1;
            new_code = ErrTimeout;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      RD_REQ: begin
        if (obi_gnt_i) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = RD_RSP;
        end
      end
      RD_RSP: begin
        if (obi_rvalid_i) begin
          new_err  = mismatch;
          new_code = ErrMismatch;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (rsp_timeout) begin
            new_err  = 1'b1;
            new_code = ErrTimeout;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // clear wins over a same-cycle error; otherwise only the first error is kept
    if (err_clr_i) begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
      err_idx_d  = '0;
    end else if (new_err && !err_q) begin
      err_d      = 1'b1;
      err_code_d = new_code;
      err_idx_d  = idx_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ctrl_q     <= '0;
      prio_q     <= '0;
      verify_q   <= 1'b0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ctrl_q     <= ctrl_d;
      prio_q     <= prio_d;
      verify_q   <= verify_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign obi_req_o   = req_q;
  assign obi_we_o    = we_q;
  assign obi_addr_o  = addr_q;
  assign obi_be_o    = be_q;
  assign obi_wdata_o = wdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign err_idx_o   = err_idx_q;

endmodule

// File: tb/tb_hetic_cfg_loader.sv
// Scoreboard bench for hetic_cfg_loader: expected OBI transactions are queued per
// command and checked by a subordinate model as the loader issues them.
module tb_hetic_cfg_loader;

  localparam int          NrIrqLines = 64;
  localparam int          NrIrqPrios = 32;
  localparam logic [31:0] BaseAddr   = 32'h0;
  localparam int          RspTimeout = 16;
  localparam int          IrqWidth   = $clog2(NrIrqLines);
  localparam int          PrioWidth  = $clog2(NrIrqPrios);

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          stall;
    int          delay;
    bit          rspEn;
    logic [31:0] rdata;
  } obi_txn_t;

  obi_txn_t expQ[$];

  logic                 clk;
  logic                 rst_n;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [IrqWidth-1:0]  cfg_idx;
  logic [5:0]           cfg_ctrl;
  logic [PrioWidth-1:0] cfg_prio;
  logic                 cfg_verify;
  logic                 obi_req;
  logic                 obi_gnt;
  logic [31:0]          obi_addr;
  logic                 obi_we;
  logic [3:0]           obi_be;
  logic [31:0]          obi_wdata;
  logic                 obi_rvalid;
  logic [31:0]          obi_rdata;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [1:0]           err_code;
  logic [IrqWidth-1:0]  err_idx;
  logic                 err_clr;

  int nAssert    = 0;
  int nFail      = 0;
  int cycCnt     = 0;
  int grantCyc   = 0;
  int rvalidCyc  = 0;
  int grantCount = 0;
  int doneCount  = 0;

  bit          mErr  = 1'b0;
  logic [1:0]  mCode = 2'b00;
  logic [31:0] mIdx  = 32'h0;

  hetic_cfg_loader #(
    .NrIrqLines(NrIrqLines),
    .NrIrqPrios(NrIrqPrios),
    .BaseAddr  (BaseAddr),
    .RspTimeout(RspTimeout)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_idx_i   (cfg_idx),
    .cfg_ctrl_i  (cfg_ctrl),
    .cfg_prio_i  (cfg_prio),
    .cfg_verify_i(cfg_verify),
    .obi_req_o   (obi_req),
    .obi_gnt_i   (obi_gnt),
    .obi_addr_o  (obi_addr),
    .obi_we_o    (obi_we),
    .obi_be_o    (obi_be),
    .obi_wdata_o (obi_wdata),
    .obi_rvalid_i(obi_rvalid),
    .obi_rdata_i (obi_rdata),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_code_o  (err_code),
    .err_idx_o   (err_idx),
    .err_clr_i   (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Register-file model: two 16-bit line slots per word, prio in the high byte of a slot
  function automatic obi_txn_t makeTxn(input logic we, input int idx, input logic [5:0] ctrl,
                                       input int prio, input int stall, input int delay,
                                       input bit rspEn, input logic [31:0] rdata);
    obi_txn_t    t;
    logic [15:0] half;
    half    = (16'(prio) << 8) | {10'h000, ctrl};
    t.we    = we;
    t.addr  = BaseAddr + 32'((idx / 2) * 4);
    t.be    = (idx % 2 == 1) ? 4'b1100 : 4'b0011;
    t.wdata = (idx % 2 == 1) ? {half, 16'h0000} : {16'h0000, half};
    t.stall = stall;
    t.delay = delay;
    t.rspEn = rspEn;
    t.rdata = rdata;
    return t;
  endfunction

  task automatic runCounter;
    forever begin
      @(posedge clk);
      cycCnt++;
    end
  endtask

  // OBI subordinate: stalls grants, checks each request against the queue head, answers later
  task automatic runSubordinate;
    int          stallLeft = 0;
    bit          inReq     = 1'b0;
    int          countdown = 0;
    bit          curEn     = 1'b0;
    logic [31:0] curData   = 32'h0;
    obi_txn_t    t;
    forever begin
      @(negedge clk);
      obi_gnt    = 1'b0;
      obi_rvalid = 1'b0;
      obi_rdata  = 32'h0;
      if (done) doneCount++;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0 && curEn) begin
          obi_rvalid = 1'b1;
          obi_rdata  = curData;
          rvalidCyc  = cycCnt + 1;
        end
      end
      if (obi_req) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_req", 32'(obi_req), 32'h0);
          obi_gnt   = 1'b1;
          countdown = 1;
          curEn     = 1'b1;
          curData   = 32'h0;
        end else begin
          if (!inReq) begin
            inReq     = 1'b1;
            stallLeft = expQ[0].stall;
          end
          t = expQ[0];
          checkOutput("req_we", 32'(obi_we), 32'(t.we));
          checkOutput("req_addr", obi_addr, t.addr);
          checkOutput("req_be", 32'(obi_be), 32'(t.be));
          if (t.we) checkOutput("req_wdata", obi_wdata, t.wdata);
          if (stallLeft > 0) begin
            stallLeft--;
          end else begin
            obi_gnt = 1'b1;
            void'(expQ.pop_front());
            inReq     = 1'b0;
            countdown = t.delay + 1;
            curEn     = t.rspEn;
            curData   = t.rdata;
            grantCyc  = cycCnt + 1;
            grantCount++;
          end
        end
      end
    end
  endtask

  task automatic sendCmd(input int idx, input logic [5:0] ctrl, input int prio, input bit verify);
    int n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_ready", 32'(cfg_ready), 32'h1);
    cfg_idx    = IrqWidth'(idx);
    cfg_ctrl   = ctrl;
    cfg_prio   = PrioWidth'(prio);
    cfg_verify = verify;
    cfg_valid  = 1'b1;
    @(negedge clk);
    cfg_valid  = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'h1);
  endtask

  task automatic checkErrState(input string tag);
    checkOutput({tag, "_err"}, 32'(err), 32'(mErr));
    checkOutput({tag, "_err_code"}, 32'(err_code), 32'(mCode));
    checkOutput({tag, "_err_idx"}, 32'(err_idx), mIdx);
  endtask

  // One full command: queue the expected write (and read-back), run it, check done and error state
  task automatic applyStimulus(input int idx, input logic [5:0] ctrl, input int prio,
                               input bit verify, input int stall, input bit rspEn,
                               input logic [31:0] rdata, input logic [1:0] expCode);
    int n = 0;
    int doneCyc;
    expQ.push_back(makeTxn(1'b1, idx, ctrl, prio, stall, 0, verify ? 1'b1 : rspEn, 32'h0));
    if (verify) expQ.push_back(makeTxn(1'b0, idx, ctrl, prio, 0, 0, rspEn, rdata));
    sendCmd(idx, ctrl, prio, verify);
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(done), 32'h1);
    doneCyc = cycCnt;
    if (rspEn) checkOutput("done_latency", 32'(doneCyc - rvalidCyc), 32'h0);
    else       checkOutput("timeout_latency", 32'(doneCyc - grantCyc), 32'(RspTimeout));
    checkOutput("ready_at_done", 32'(cfg_ready), 32'h1);
    checkOutput("busy_at_done", 32'(busy), 32'h0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    if (expCode != 2'b00 && !mErr) begin
      mErr  = 1'b1;
      mCode = expCode;
      mIdx  = 32'(idx);
    end
    checkErrState("cmd");
    @(negedge clk);
    checkOutput("done_pulse_width", 32'(done), 32'h0);
  endtask

  task automatic errClear;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    mErr  = 1'b0;
    mCode = 2'b00;
    mIdx  = 32'h0;
    checkErrState("clear");
  endtask

  initial begin
    int g0;
    int dc;
    int n;
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_idx    = '0;
    cfg_ctrl   = '0;
    cfg_prio   = '0;
    cfg_verify = 1'b0;
    obi_gnt    = 1'b0;
    obi_rvalid = 1'b0;
    obi_rdata  = 32'h0;
    err_clr    = 1'b0;
    fork
      runCounter;
      runSubordinate;
    join_none

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(cfg_ready), 32'h1);
    checkOutput("rst_req", 32'(obi_req), 32'h0);
    checkOutput("rst_we", 32'(obi_we), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_addr", obi_addr, 32'h0);
    checkOutput("rst_be", 32'(obi_be), 32'h0);
    checkOutput("rst_wdata", obi_wdata, 32'h0);
    checkErrState("rst");
    rst_n = 1'b1;

    $display("[TB] plain write, odd line");
    applyStimulus(5, 6'b000001, 7, 1'b0, 0, 1'b1, 32'h0, 2'b00);
    $display("[TB] write with verify, even line");
    applyStimulus(4, 6'b110101, 31, 1'b1, 0, 1'b1, 32'h0000_1F35, 2'b00);
    $display("[TB] verify ignores ip bit");
    applyStimulus(4, 6'b110101, 31, 1'b1, 0, 1'b1, 32'h0000_1F37, 2'b00);
    $display("[TB] verify odd line, don't-care bits set");
    applyStimulus(9, 6'b101110, 12, 1'b1, 0, 1'b1, 32'hCC2E_ABCD, 2'b00);
    $display("[TB] verify mismatch on priority");
    applyStimulus(4, 6'b110101, 31, 1'b1, 0, 1'b1, 32'h0000_1E35, 2'b01);
    errClear();
    $display("[TB] grant stall of 5 cycles");
    applyStimulus(20, 6'b010100, 3, 1'b0, 5, 1'b1, 32'h0, 2'b00);
    $display("[TB] response timeout");
    applyStimulus(33, 6'b000011, 1, 1'b0, 0, 1'b0, 32'h0, 2'b10);
    $display("[TB] command after timeout");
    applyStimulus(2, 6'b000000, 0, 1'b0, 0, 1'b1, 32'h0, 2'b00);
    $display("[TB] second error does not overwrite first");
    applyStimulus(7, 6'b000001, 5, 1'b1, 0, 1'b1, 32'h0000_0000, 2'b01);
    errClear();

    $display("[TB] reset during read response");
    g0 = grantCount;
    expQ.push_back(makeTxn(1'b1, 10, 6'b000101, 2, 0, 0, 1'b1, 32'h0));
    expQ.push_back(makeTxn(1'b0, 10, 6'b000101, 2, 0, 8, 1'b1, 32'h0000_0205));
    sendCmd(10, 6'b000101, 2, 1'b1);
    n = 0;
    while (grantCount < g0 + 2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("read_granted", 32'(grantCount - g0), 32'h2);
    @(negedge clk);
    checkOutput("rd_rsp_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_req", 32'(obi_req), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postrst_ready", 32'(cfg_ready), 32'h1);
    checkOutput("postrst_busy", 32'(busy), 32'h0);
    dc = doneCount;
    repeat (12) @(negedge clk);
    checkOutput("stale_rsp_done", 32'(doneCount - dc), 32'h0);
    checkErrState("stale_rsp");
    checkOutput("final_queue", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
